fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that consumes the branch comparator result and the jump controls resolved in EX.
- Owns the architectural PC and computes redirect targets.
- Issues single-outstanding requests to instruction memory and presents fetched instructions to decode through a valid/ready handshake.
- Sits directly upstream of decode. Closes the control-flow loop from the branch unit in EX back to IF.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_AW, 32, instruction address width; fixed at 32 for RV32I.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  EX/ID hazard hold; redirect inputs are ignored while 1
- br_en  in  1  EX instruction is a conditional branch
- br_res  in  1  branch-condition result from the branch unit
- jal  in  1  EX instruction is JAL
- jalr  in  1  EX instruction is JALR
- ex_pc  in  32  PC of the EX instruction
- ex_imm  in  32  sign-extended immediate of the EX instruction
- ex_rs1  in  32  rs1 operand, used for JALR
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  read data valid; never earlier than the cycle after gnt
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- id_ready  in  1  decode accepts the instruction
- flush  out  1  1-cycle pulse; kills younger instructions in ID/EX
- misalign_exc  out  1  1-cycle pulse; taken target not 4-byte aligned
- misalign_addr  out  32  offending target, valid with misalign_exc

Behaviour:
- Reset (rst_n=0 at a clock edge) has priority over everything, including mid-transaction: pc=RESET_PC, state=IDLE, discard=0.
  - Outputs at reset: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, flush=0, misalign_exc=0, misalign_addr=0.
  - Any in-flight response arriving after reset is ignored.
- Redirect decode, combinational:
  - take = !stall & ((br_en & br_res) | jal | jalr).
  - target = jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm). Modulo-2^32 add, wraps silently.
  - If take and target[1]=1: misalign_exc=1 and misalign_addr=target for one cycle. No redirect, no flush; PC and state continue unaffected.
  - If take and aligned: redirect. flush=1 for that cycle; pc<=target.
  - br_en=0 makes br_res a don't-care. jal and jalr are never both 1.
- State machine, IDLE/REQ/WAIT/HOLD:
  - IDLE: entered only from reset. Next cycle goes to REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - gnt=1 → WAIT, with fetch_addr<=pc.
    - Redirect with gnt=0 → pc<=target, stay REQ (address switches next cycle).
    - Redirect with gnt=1 → WAIT with discard<=1.
  - WAIT: imem_req=0.
    - Redirect → pc<=target, discard<=1.
    - rvalid with discard=1 → discard<=0, go to REQ.
    - rvalid with discard=0 and no redirect → if_instr<=rdata, if_pc<=fetch_addr, if_valid<=1, pc<=fetch_addr+4, go to HOLD.
    - rvalid with a same-cycle redirect is treated as discard.
  - HOLD: if_valid=1; if_instr and if_pc are held stable until the transfer completes.
    - if_valid & id_ready & !redirect → if_valid<=0, go to REQ.
    - Redirect → if_valid<=0 (instruction killed), pc<=target, go to REQ. Redirect wins over a same-cycle id_ready.
- Best-case latency: REQ+gnt at cycle n, rvalid at n+1, if_valid at n+2. One instruction per 3 cycles.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Test Plan:
1. Reset with RESET_PC=0x100; release; gnt immediately, rvalid next cycle with 0x00500093 → imem_addr=0x100; if_valid with if_pc=0x100, if_instr=0x00500093; next imem_addr=0x104.
2. BEQ taken: br_en=1, br_res=1, ex_pc=0x200, ex_imm=0x40, in HOLD → flush pulse, if_valid drops, next imem_addr=0x240; br_res=0 → no flush, sequential fetch.
3. JALR: ex_rs1=0x1001, ex_imm=0x4 → target 0x1004 (bit0 cleared); ex_rs1=0x1002, ex_imm=0 → misalign_exc=1, misalign_addr=0x1002, no flush, sequential PC retained.
4. Redirect in WAIT to 0x300 → returned rdata dropped (if_valid stays 0), next imem_addr=0x300; also redirect together with rvalid in the same cycle → same result.
5. stall=1 with jal=1, ex_pc=0x10, ex_imm=0x20 → no flush, no redirect; stall drops → redirect to 0x30. if_valid held with id_ready=0 for 5 cycles → if_instr/if_pc stable throughout.
6. rst_n=0 asserted in WAIT, rvalid arrives during reset → all outputs at reset values, fetch restarts at RESET_PC, the stale response is never presented.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the architectural PC, resolves redirects from EX,
// issues single-outstanding imem requests and hands instructions to decode.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               br_en,
   input  logic               br_res,
   input  logic               jal,
   input  logic               jalr,
   input  logic [31:0]        ex_pc,
   input  logic [31:0]        ex_imm,
   input  logic [31:0]        ex_rs1,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [31:0]        imem_rdata,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [31:0]        if_pc,
   input  logic               id_ready,
   output logic               flush,
   output logic               misalign_exc,
   output logic [31:0]        misalign_addr
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   // decoded control-flow change coming back from EX
   typedef struct packed {
      logic        take;     // EX wants to change flow
      logic        redirect; // taken and aligned: actually steer the PC
      logic        misalign; // taken but target not word aligned
      logic [31:0] target;
   } redir_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] fetch_addr;
   logic        discard;
   redir_t      rd;
   logic [31:0] base;
   logic [31:0] sum;

   // redirect decode; JALR clears bit 0 of the sum, only bit 1 is an alignment fault
   always_comb begin
      base        = jalr ? ex_rs1 : ex_pc;
      sum         = base + ex_imm;
      rd.target   = jalr ? {sum[31:1], 1'b0} : sum;
      rd.take     = !stall && ((br_en && br_res) || jal || jalr);
      rd.redirect = rd.take && !rd.target[1];
      rd.misalign = rd.take &&  rd.target[1];
   end

   // pulses are gated by reset so nothing leaks out while the unit is held
   always_comb begin
      flush         = rst_n && rd.redirect;
      misalign_exc  = rst_n && rd.misalign;
      misalign_addr = misalign_exc ? rd.target : 32'h0;
      imem_req      = (state == S_REQ);
      imem_addr     = pc;
   end

   // fetch state machine, PC and the decode-facing instruction register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         fetch_addr <= RESET_PC;
         discard    <= 1'b0;
         if_valid   <= 1'b0;
         if_instr   <= NOP;
         if_pc      <= RESET_PC;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_REQ;
               if (rd.redirect) pc <= rd.target;
            end

            S_REQ: begin
               if (rd.redirect) pc <= rd.target;
               if (imem_gnt) begin
                  // a redirect coinciding with the grant makes this response stale
                  state      <= S_WAIT;
                  fetch_addr <= pc;
                  discard    <= rd.redirect;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  if (discard || rd.redirect) begin
                     discard <= 1'b0;
                     state   <= S_REQ;
                     if (rd.redirect) pc <= rd.target;
                  end else begin
                     if_instr <= imem_rdata;
                     if_pc    <= fetch_addr;
                     if_valid <= 1'b1;
                     pc       <= fetch_addr + 32'd4;
                     state    <= S_HOLD;
                  end
               end else if (rd.redirect) begin
                  pc      <= rd.target;
                  discard <= 1'b1;
               end
            end

            S_HOLD: begin
               // redirect kills the held instruction even if decode takes it this cycle
               if (rd.redirect) begin
                  if_valid <= 1'b0;
                  pc       <= rd.target;
                  state    <= S_REQ;
               end else if (id_ready) begin
                  if_valid <= 1'b0;
                  state    <= S_REQ;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
